// File: rtl/cml_axil_cmd_master.sv
// AXI4-Lite master: turns single-word register commands into one AXI4-Lite
// read or write each, with a per-transaction timeout and exactly one response per command.
module cml_axil_cmd_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASEADDR = 32'h77e20000,
   parameter int C_TIMEOUT_CYCLES = 256
) (
   input  logic                          axi_aclk,
   input  logic                          axi_areset,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_rnw,
   input  logic [15:0]                   cmd_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic                          rsp_timeout,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP} state_t;

   localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

   state_t                          state_q, state_d;
   logic [15:0]                     timer_q, timer_d;
   logic                            abort;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_axi_addr;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_d, araddr_d;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_d, rsp_rdata_d;
   logic [1:0]                      rsp_resp_d;
   logic                            rsp_timeout_d;
   logic                            awvalid_d, wvalid_d, arvalid_d;
   logic                            unused_addr_bits;

   assign unused_addr_bits = &{1'b0, cmd_addr[1:0]};
   assign cmd_axi_addr = C_BASEADDR |
                         {{(C_M_AXI_ADDR_WIDTH-16){1'b0}}, cmd_addr[15:2], 2'b00};

   // All outputs are registered, so next-state logic also produces the next
   // value of every output; the ready/valid levels follow the next state.
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= 2'b00;
         rsp_timeout   <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         cmd_ready     <= (state_d == IDLE);
         rsp_valid     <= (state_d == RSP);
         rsp_rdata     <= rsp_rdata_d;
         rsp_resp      <= rsp_resp_d;
         rsp_timeout   <= rsp_timeout_d;
         m_axi_awaddr  <= awaddr_d;
         m_axi_awvalid <= awvalid_d;
         m_axi_wdata   <= wdata_d;
         m_axi_wvalid  <= wvalid_d;
         m_axi_bready  <= (state_d == IDLE) || (state_d == WR_RSP) || (state_d == RSP);
         m_axi_araddr  <= araddr_d;
         m_axi_arvalid <= arvalid_d;
         m_axi_rready  <= (state_d == IDLE) || (state_d == RD_RSP) || (state_d == RSP);
      end
   end

   // Response fields change only on entry to RSP, so late B/R beats absorbed
   // in IDLE or RSP can never disturb a pending response.
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      abort         = 1'b0;
      awaddr_d      = m_axi_awaddr;
      araddr_d      = m_axi_araddr;
      wdata_d       = m_axi_wdata;
      awvalid_d     = m_axi_awvalid;
      wvalid_d      = m_axi_wvalid;
      arvalid_d     = m_axi_arvalid;
      rsp_rdata_d   = rsp_rdata;
      rsp_resp_d    = rsp_resp;
      rsp_timeout_d = rsp_timeout;

      if (state_q != IDLE && state_q != RSP) begin
         timer_d = timer_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               timer_d = '0;
               if (cmd_rnw) begin
                  araddr_d  = cmd_axi_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end else begin
                  awaddr_d  = cmd_axi_addr;
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            awvalid_d = m_axi_awvalid && !m_axi_awready;
            wvalid_d  = m_axi_wvalid && !m_axi_wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d = WR_RSP;
            end else if (timer_q == TMO_LAST) begin
               abort = 1'b1;
            end
         end
         WR_RSP: begin
            if (m_axi_bvalid) begin
               rsp_resp_d    = m_axi_bresp;
               rsp_rdata_d   = '0;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end else if (timer_q == TMO_LAST) begin
               abort = 1'b1;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_RSP;
            end else if (timer_q == TMO_LAST) begin
               abort = 1'b1;
            end
         end
         RD_RSP: begin
            if (m_axi_rvalid) begin
               rsp_rdata_d   = m_axi_rdata;
               rsp_resp_d    = m_axi_rresp;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end else if (timer_q == TMO_LAST) begin
               abort = 1'b1;
            end
         end
         RSP: begin
            if (rsp_ready && rsp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         arvalid_d     = 1'b0;
         rsp_resp_d    = 2'b10;
         rsp_rdata_d   = '0;
         rsp_timeout_d = 1'b1;
         state_d       = RSP;
      end
   end

endmodule
